pueo_command_encoder: RTL and testbench



---
 rtl/pueo_command_pkg.sv | 33 +++
 rtl/pueo_command_encoder_if.sv | 29 ++
 rtl/pueo_cmd_trig_fifo.sv | 88 ++++++++
 rtl/pueo_command_encoder.sv | 113 +++++++++++
 tb/tb_pueo_command_encoder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pueo_command_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pueo_command_pkg
//  Description : Shared bit layout of the 32-bit TURF->TURFIO command word.
//  Revision    : 1.0 - initial release
// ============================================================================
package pueo_command_pkg;

    localparam int CMD_SYNC_BIT       = 31;
    localparam int CMD_PPS_BIT        = 30;
    localparam int CMD_TRIGV_BIT      = 29;
    localparam int CMD_TRIGTIME_LSB   = 14;
    localparam int CMD_TRIGTIME_BITS  = 15;
    localparam int CMD_VALID_BIT      = 13;
    localparam int CMD_LAST_BIT       = 12;
    localparam int CMD_RST_BIT        = 11;
    localparam int CMD_DATA_BITS      = 8;

    // Same layout as the flat word; the decoder unpacks through this type.
    typedef struct packed {
        logic                         sync;
        logic                         pps;
        logic                         trig_valid;
        logic [CMD_TRIGTIME_BITS-1:0] trig_time;
        logic                         cmd_valid;
        logic                         cmd_last;
        logic                         cmd_rst;
        logic [2:0]                   reserved;
        logic [CMD_DATA_BITS-1:0]     cmd_data;
    } pueo_command_t;

endpackage
`default_nettype wire

// File: rtl/pueo_command_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pueo_command_encoder_if
//  Description : Command-processor byte stream feeding the command encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pueo_command_encoder_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface
`default_nettype wire

// File: rtl/pueo_cmd_trig_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pueo_cmd_trig_fifo
//  Description : Circular trigger-time queue with full/empty and sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module pueo_cmd_trig_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_head,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_overflow
);

    localparam int               c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               c_CW   = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0]  c_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_full;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [c_CW-1:0]  w_count_next;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign w_push  = i_push & (~w_full | w_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CW'(1);
            2'b01:   w_count_next = r_count - c_CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FULL);
            if (i_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_empty    = w_empty;
    assign o_full     = r_full;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pueo_command_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : pueo_command_encoder
//  Description : Packs sync/PPS flags, one command byte and one trigger time
//                into a 32-bit command word per sysclk slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module pueo_command_encoder
    import pueo_command_pkg::*;
#(
    parameter int TRIG_DEPTH     = 4,
    parameter int TRIG_TIME_BITS = 15
) (
    input  wire logic                      sysclk_i,
    input  wire logic                      rst_i,
    input  wire logic                      sync_i,
    input  wire logic                      sync_req_i,
    input  wire logic                      pps_req_i,
    input  wire logic                      cmdproc_rst_i,
    pueo_command_encoder_if.slave          s_cmd,
    input  wire logic [TRIG_TIME_BITS-1:0] trig_time_i,
    input  wire logic                      trig_valid_i,
    output logic                           trig_full_o,
    output logic                           trig_overflow_o,
    output logic [31:0]                    command_o,
    output logic                           command_valid_o
);

    logic                      r_pend_sync;
    logic                      r_pend_pps;
    logic                      r_pend_rst;
    logic [31:0]               r_command;
    logic                      r_command_valid;

    logic                      w_sync_flag;
    logic                      w_pps_flag;
    logic                      w_rst_flag;
    logic                      w_tready;
    logic                      w_byte_hs;
    logic [TRIG_TIME_BITS-1:0] w_trig_head;
    logic                      w_trig_empty;
    logic                      w_trig_take;
    logic [31:0]               w_word;

    // Requests landing on the slot cycle itself still make this slot.
    assign w_sync_flag = r_pend_sync | sync_req_i;
    assign w_pps_flag  = r_pend_pps  | pps_req_i;
    assign w_rst_flag  = r_pend_rst  | cmdproc_rst_i;

    assign w_tready     = sync_i & ~rst_i & ~w_rst_flag;
    assign w_byte_hs    = s_cmd.tvalid & w_tready;
    assign s_cmd.tready = w_tready;

    assign w_trig_take = sync_i & ~w_trig_empty;

    pueo_cmd_trig_fifo #(
        .DEPTH (TRIG_DEPTH),
        .WIDTH (TRIG_TIME_BITS)
    ) u_trig_fifo (
        .clk        (sysclk_i),
        .rst        (rst_i),
        .i_push     (trig_valid_i),
        .i_data     (trig_time_i),
        .i_pop      (sync_i),
        .o_head     (w_trig_head),
        .o_empty    (w_trig_empty),
        .o_full     (trig_full_o),
        .o_overflow (trig_overflow_o)
    );

    always_comb begin
        w_word                = '0;
        w_word[CMD_SYNC_BIT]  = w_sync_flag;
        w_word[CMD_PPS_BIT]   = w_pps_flag;
        w_word[CMD_RST_BIT]   = w_rst_flag;
        if (w_trig_take) begin
            w_word[CMD_TRIGV_BIT]                               = 1'b1;
            w_word[CMD_TRIGTIME_LSB +: CMD_TRIGTIME_BITS]       = w_trig_head;
        end
        if (w_byte_hs) begin
            w_word[CMD_VALID_BIT]                               = 1'b1;
            w_word[CMD_LAST_BIT]                                = s_cmd.tlast;
            w_word[CMD_DATA_BITS-1:0]                           = s_cmd.tdata;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            r_pend_sync     <= 1'b0;
            r_pend_pps      <= 1'b0;
            r_pend_rst      <= 1'b0;
            r_command       <= '0;
            r_command_valid <= 1'b0;
        end else begin
            r_command_valid <= sync_i;
            if (sync_i) begin
                r_command   <= w_word;
                r_pend_sync <= 1'b0;
                r_pend_pps  <= 1'b0;
                r_pend_rst  <= 1'b0;
            end else begin
                r_pend_sync <= w_sync_flag;
                r_pend_pps  <= w_pps_flag;
                r_pend_rst  <= w_rst_flag;
            end
        end
    end

    assign command_o       = r_command;
    assign command_valid_o = r_command_valid;

endmodule
`default_nettype wire

// File: tb/tb_pueo_command_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pueo_command_encoder
//  Description : Directed vector bench for the TURF command encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pueo_command_encoder;

    logic        sysclk_i = 1'b0;
    logic        rst_i;
    logic        sync_i;
    logic        sync_req_i;
    logic        pps_req_i;
    logic        cmdproc_rst_i;
    logic [14:0] trig_time_i;
    logic        trig_valid_i;
    logic        trig_full_o;
    logic        trig_overflow_o;
    logic [31:0] command_o;
    logic        command_valid_o;

    pueo_command_encoder_if cmd_if ();

    pueo_command_encoder #(
        .TRIG_DEPTH     (4),
        .TRIG_TIME_BITS (15)
    ) dut (
        .sysclk_i        (sysclk_i),
        .rst_i           (rst_i),
        .sync_i          (sync_i),
        .sync_req_i      (sync_req_i),
        .pps_req_i       (pps_req_i),
        .cmdproc_rst_i   (cmdproc_rst_i),
        .s_cmd           (cmd_if.slave),
        .trig_time_i     (trig_time_i),
        .trig_valid_i    (trig_valid_i),
        .trig_full_o     (trig_full_o),
        .trig_overflow_o (trig_overflow_o),
        .command_o       (command_o),
        .command_valid_o (command_valid_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    typedef struct {
        logic        sreq;
        logic        preq;
        logic        rreq;
        logic        on_slot;
        logic        bv;
        logic [7:0]  bd;
        logic        bl;
        int          ntrig;
        logic [14:0] t0;
        logic [14:0] t1;
        logic [31:0] exp_word;
        logic        exp_rdy;
    } vec_t;

    localparam int c_NVEC = 15;
    vec_t vecs [c_NVEC];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge sysclk_i);
        #1;
    endtask

    task automatic idle_inputs();
        sync_i        = 1'b0;
        sync_req_i    = 1'b0;
        pps_req_i     = 1'b0;
        cmdproc_rst_i = 1'b0;
        trig_valid_i  = 1'b0;
        trig_time_i   = '0;
        cmd_if.tvalid = 1'b0;
        cmd_if.tdata  = '0;
        cmd_if.tlast  = 1'b0;
    endtask

    // One 16-cycle period; the slot strobe sits on the last cycle.
    task automatic run_vec(input vec_t v, input int idx);
        for (int c = 0; c < 16; c++) begin
            sync_i        = (c == 15);
            sync_req_i    = v.sreq && (v.on_slot ? (c == 15) : (c == 10));
            pps_req_i     = v.preq && (v.on_slot ? (c == 15) : (c == 10));
            cmdproc_rst_i = v.rreq && (v.on_slot ? (c == 15) : (c == 10));
            trig_valid_i  = (v.ntrig > 0 && c == 3) || (v.ntrig > 1 && c == 4);
            trig_time_i   = (c == 4) ? v.t1 : v.t0;
            cmd_if.tvalid = v.bv;
            cmd_if.tdata  = v.bd;
            cmd_if.tlast  = v.bl;
            if (c == 15) begin
                #1;
                chk($sformatf("vec%0d_tready", idx), {31'b0, cmd_if.tready}, {31'b0, v.exp_rdy});
            end else if (c == 7) begin
                chk($sformatf("vec%0d_tready_off", idx), {31'b0, cmd_if.tready}, 32'd0);
            end
            tick();
            if (c == 7) chk($sformatf("vec%0d_valid_low", idx), {31'b0, command_valid_o}, 32'd0);
        end
        chk($sformatf("vec%0d_valid", idx), {31'b0, command_valid_o}, 32'd1);
        chk($sformatf("vec%0d_word", idx), command_o, v.exp_word);
    endtask

    task automatic slot_tick(input string name, input logic [31:0] exp);
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
        chk({name, "_valid"}, {31'b0, command_valid_o}, 32'd1);
        chk({name, "_word"}, command_o, exp);
    endtask

    task automatic push(input logic [14:0] t);
        trig_valid_i = 1'b1;
        trig_time_i  = t;
        tick();
        trig_valid_i = 1'b0;
    endtask

    initial begin
        //            sreq  preq  rreq  onslt bv    bd     bl    nt t0       t1       exp            rdy
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 15'h0000, 15'h0000, 32'h0000_0000, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 15'h0000, 15'h0000, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 15'h0000, 15'h0000, 32'h8000_0000, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 15'h0000, 15'h0000, 32'h4000_0000, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 15'h0000, 15'h0000, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 0, 15'h0000, 15'h0000, 32'h0000_20A5, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 0, 15'h0000, 15'h0000, 32'h0000_303C, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 0, 15'h0000, 15'h0000, 32'h0000_0800, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 0, 15'h0000, 15'h0000, 32'h0000_2011, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2, 15'h1234, 15'h0001, 32'h248D_0000, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 15'h0000, 15'h0000, 32'h2000_4000, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 15'h0000, 15'h0000, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b1, 1, 15'h7FFF, 15'h0000, 32'hFFFF_F07E, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 0, 15'h0000, 15'h0000, 32'h0000_0800, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 0, 15'h0000, 15'h0000, 32'h0000_2055, 1'b1};

        idle_inputs();
        rst_i = 1'b1;
        repeat (3) tick();
        chk("rst_command", command_o, 32'h0);
        chk("rst_valid", {31'b0, command_valid_o}, 32'd0);
        chk("rst_tready", {31'b0, cmd_if.tready}, 32'd0);
        chk("rst_full", {31'b0, trig_full_o}, 32'd0);
        chk("rst_overflow", {31'b0, trig_overflow_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < c_NVEC; i++) run_vec(vecs[i], i);
        idle_inputs();

        // Back-to-back slot strobes, then command_o holds.
        push(15'h0002);
        push(15'h0003);
        slot_tick("b2b0", 32'h2000_8000);
        slot_tick("b2b1", 32'h2000_C000);
        tick();
        chk("b2b_valid_drop", {31'b0, command_valid_o}, 32'd0);
        chk("b2b_hold", command_o, 32'h2000_C000);

        // Push on a slot with an empty queue waits for the next slot.
        trig_valid_i = 1'b1;
        trig_time_i  = 15'h0055;
        slot_tick("nobypass0", 32'h0000_0000);
        trig_valid_i = 1'b0;
        repeat (4) tick();
        slot_tick("nobypass1", 32'h2015_4000);

        // Five pushes into a depth-4 queue with no slots in between.
        tick();
        chk("full_before", {31'b0, trig_full_o}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            push(15'(16 + k));
            if (k == 3) begin
                chk("full_at4", {31'b0, trig_full_o}, 32'd1);
                chk("ovf_at4", {31'b0, trig_overflow_o}, 32'd0);
            end
        end
        chk("full_at5", {31'b0, trig_full_o}, 32'd1);
        chk("ovf_at5", {31'b0, trig_overflow_o}, 32'd1);
        slot_tick("drain0", 32'h2004_0000);
        slot_tick("drain1", 32'h2004_4000);
        slot_tick("drain2", 32'h2004_8000);
        slot_tick("drain3", 32'h2004_C000);
        chk("full_drained", {31'b0, trig_full_o}, 32'd0);
        chk("ovf_sticky", {31'b0, trig_overflow_o}, 32'd1);
        slot_tick("drain_empty", 32'h0000_0000);

        // Reset mid-operation with queued triggers and a pending SYNC.
        push(15'h0021);
        push(15'h0022);
        push(15'h0023);
        sync_req_i = 1'b1;
        tick();
        sync_req_i = 1'b0;
        rst_i  = 1'b1;
        sync_i = 1'b1;
        #1;
        chk("rst_mid_tready", {31'b0, cmd_if.tready}, 32'd0);
        tick();
        sync_i = 1'b0;
        chk("rst_mid_valid", {31'b0, command_valid_o}, 32'd0);
        chk("rst_mid_command", command_o, 32'h0);
        chk("rst_mid_overflow", {31'b0, trig_overflow_o}, 32'd0);
        chk("rst_mid_full", {31'b0, trig_full_o}, 32'd0);
        rst_i = 1'b0;
        repeat (3) tick();
        slot_tick("post_rst0", 32'h0000_0000);
        slot_tick("post_rst1", 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
